// File: rtl/accelerator_trainer_pkg.sv
// Definitions shared by the FNN trainer and its input feeder: FSM state codes,
// the read tag that travels with each buffer access, and constant words.
package accelerator_trainer_pkg;

  localparam int DATA_SIZE_DEFAULT    = 64;
  localparam int CONTROL_SIZE_DEFAULT = 64;

  localparam logic [DATA_SIZE_DEFAULT-1:0]    ZERO_DATA    = 64'd0;
  localparam logic [DATA_SIZE_DEFAULT-1:0]    ONE_DATA     = 64'd1;
  localparam logic [CONTROL_SIZE_DEFAULT-1:0] ZERO_CONTROL = 64'd0;
  localparam logic [CONTROL_SIZE_DEFAULT-1:0] ONE_CONTROL  = 64'd1;

  localparam logic [2:0] STARTER = 3'd0;
  localparam logic [2:0] READ_X  = 3'd1;
  localparam logic [2:0] READ_R  = 3'd2;
  localparam logic [2:0] READ_H  = 3'd3;
  localparam logic [2:0] DRAIN   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [1:0] PHASE_X = 2'd0;
  localparam logic [1:0] PHASE_R = 2'd1;
  localparam logic [1:0] PHASE_H = 2'd2;

  typedef struct packed {
    logic [1:0] phase;
    logic       first;
  } read_tag_t;

  localparam read_tag_t TAG_X       = '{phase: PHASE_X, first: 1'b0};
  localparam read_tag_t TAG_R       = '{phase: PHASE_R, first: 1'b0};
  localparam read_tag_t TAG_R_FIRST = '{phase: PHASE_R, first: 1'b1};
  localparam read_tag_t TAG_H       = '{phase: PHASE_H, first: 1'b0};

endpackage

// File: rtl/accelerator_read_aligner.sv
// Two-stage valid/tag pipeline matching the one-cycle operand buffer latency
// plus the output register stage, so each strobe leaves with its data word.
module accelerator_read_aligner #(
  parameter int TAG_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mid_valid,
  output logic [TAG_W-1:0] mid_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mid_valid <= 1'b0;
      mid_tag   <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
    end else begin
      mid_valid <= req_valid;
      mid_tag   <= req_tag;
      out_valid <= mid_valid;
      out_tag   <= mid_tag;
    end
  end

endmodule

// File: rtl/accelerator_trainer_feeder.sv
// Walks one contiguous operand-buffer region (x, then r by head/element, then h)
// and streams each word to the trainer's X/R/H ports with its strobes.
module accelerator_trainer_feeder
  import accelerator_trainer_pkg::*;
#(
  parameter int DATA_SIZE    = DATA_SIZE_DEFAULT,
  parameter int CONTROL_SIZE = CONTROL_SIZE_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_X_IN,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic [DATA_SIZE-1:0] SIZE_L_IN,
  input  logic [DATA_SIZE-1:0] SIZE_R_IN,
  output logic [DATA_SIZE-1:0] ADDRESS_OUT,
  output logic                 READ_ENABLE_OUT,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic                 X_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] X_OUT,
  output logic                 R_OUT_I_ENABLE,
  output logic                 R_OUT_K_ENABLE,
  output logic [DATA_SIZE-1:0] R_OUT,
  output logic                 H_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] H_OUT
);

  logic [2:0]              state, state_next;
  logic [DATA_SIZE-1:0]    size_x_q, size_w_q, size_l_q, size_r_q;
  logic [DATA_SIZE-1:0]    addr_q;
  logic [CONTROL_SIZE-1:0] elem_cnt, i_cnt, k_cnt;
  logic                    x_last, k_last, i_last, h_last;
  logic                    x_ne_in, r_ne_in, l_ne_in, r_ne_q, l_ne_q;
  logic                    read_en, mid_valid, out_valid;
  read_tag_t               req_tag, mid_tag, out_tag;
  logic                    ready_q;
  logic [DATA_SIZE-1:0]    x_q, r_q, h_q;

  assign x_ne_in = (SIZE_X_IN != ZERO_DATA);
  assign r_ne_in = (SIZE_R_IN != ZERO_DATA) && (SIZE_W_IN != ZERO_DATA);
  assign l_ne_in = (SIZE_L_IN != ZERO_DATA);
  assign r_ne_q  = (size_r_q != ZERO_DATA) && (size_w_q != ZERO_DATA);
  assign l_ne_q  = (size_l_q != ZERO_DATA);

  assign x_last = (elem_cnt == CONTROL_SIZE'(size_x_q) - ONE_CONTROL);
  assign h_last = (elem_cnt == CONTROL_SIZE'(size_l_q) - ONE_CONTROL);
  assign k_last = (k_cnt == CONTROL_SIZE'(size_w_q) - ONE_CONTROL);
  assign i_last = (i_cnt == CONTROL_SIZE'(size_r_q) - ONE_CONTROL);

  always_comb begin
    state_next = state;
    case (state)
      STARTER: begin
        if (START) begin
          if (x_ne_in)      state_next = READ_X;
          else if (r_ne_in) state_next = READ_R;
          else if (l_ne_in) state_next = READ_H;
          else              state_next = DONE;
        end
      end
      READ_X: begin
        if (x_last) begin
          if (r_ne_q)      state_next = READ_R;
          else if (l_ne_q) state_next = READ_H;
          else             state_next = DRAIN;
        end
      end
      READ_R: begin
        if (k_last && i_last) state_next = l_ne_q ? READ_H : DRAIN;
      end
      READ_H: begin
        if (h_last) state_next = DRAIN;
      end
      // The last word is on DATA_IN now and lands in its output register at this edge.
      DRAIN:   state_next = DONE;
      DONE:    state_next = STARTER;
      default: state_next = STARTER;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= STARTER;
      ready_q  <= 1'b0;
      size_x_q <= ZERO_DATA;
      size_w_q <= ZERO_DATA;
      size_l_q <= ZERO_DATA;
      size_r_q <= ZERO_DATA;
      addr_q   <= ZERO_DATA;
      elem_cnt <= ZERO_CONTROL;
      i_cnt    <= ZERO_CONTROL;
      k_cnt    <= ZERO_CONTROL;
    end else begin
      state   <= state_next;
      ready_q <= (state == DONE);
      case (state)
        STARTER: begin
          if (START) begin
            size_x_q <= SIZE_X_IN;
            size_w_q <= SIZE_W_IN;
            size_l_q <= SIZE_L_IN;
            size_r_q <= SIZE_R_IN;
            addr_q   <= ZERO_DATA;
            elem_cnt <= ZERO_CONTROL;
            i_cnt    <= ZERO_CONTROL;
            k_cnt    <= ZERO_CONTROL;
          end
        end
        READ_X: begin
          addr_q   <= addr_q + ONE_DATA;
          elem_cnt <= x_last ? ZERO_CONTROL : elem_cnt + ONE_CONTROL;
        end
        READ_R: begin
          addr_q <= addr_q + ONE_DATA;
          if (k_last) begin
            k_cnt <= ZERO_CONTROL;
            i_cnt <= i_last ? ZERO_CONTROL : i_cnt + ONE_CONTROL;
          end else begin
            k_cnt <= k_cnt + ONE_CONTROL;
          end
        end
        READ_H: begin
          addr_q   <= addr_q + ONE_DATA;
          elem_cnt <= h_last ? ZERO_CONTROL : elem_cnt + ONE_CONTROL;
        end
        default: ;
      endcase
    end
  end

  assign read_en = (state == READ_X) || (state == READ_R) || (state == READ_H);

  always_comb begin
    req_tag = TAG_H;
    if (state == READ_X)      req_tag = TAG_X;
    else if (state == READ_R) req_tag = (k_cnt == ZERO_CONTROL) ? TAG_R_FIRST : TAG_R;
  end

  accelerator_read_aligner #(
    .TAG_W($bits(read_tag_t))
  ) u_aligner (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (read_en),
    .req_tag   (req_tag),
    .mid_valid (mid_valid),
    .mid_tag   (mid_tag),
    .out_valid (out_valid),
    .out_tag   (out_tag)
  );

  // Output words are captured from DATA_IN while their tag sits in the middle stage.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      x_q <= ZERO_DATA;
      r_q <= ZERO_DATA;
      h_q <= ZERO_DATA;
    end else if (mid_valid) begin
      case (mid_tag)
        TAG_X:              x_q <= DATA_IN;
        TAG_R, TAG_R_FIRST: r_q <= DATA_IN;
        TAG_H:              h_q <= DATA_IN;
        default: ;
      endcase
    end
  end

  assign READ_ENABLE_OUT = read_en;
  assign ADDRESS_OUT     = addr_q;
  assign READY           = ready_q;
  assign X_OUT           = x_q;
  assign R_OUT           = r_q;
  assign H_OUT           = h_q;
  assign X_OUT_ENABLE    = out_valid && (out_tag.phase == PHASE_X);
  assign R_OUT_K_ENABLE  = out_valid && (out_tag.phase == PHASE_R);
  assign R_OUT_I_ENABLE  = out_valid && (out_tag.phase == PHASE_R) && out_tag.first;
  assign H_OUT_ENABLE    = out_valid && (out_tag.phase == PHASE_H);

endmodule

// File: tb/tb_accelerator_trainer_feeder.sv
// Directed bench for accelerator_trainer_feeder with a synchronous-read buffer
// model holding 100+address at every location.
module tb_accelerator_trainer_feeder;

  localparam int DW = 64;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic [DW-1:0] SIZE_X_IN = '0, SIZE_W_IN = '0, SIZE_L_IN = '0, SIZE_R_IN = '0;
  logic [DW-1:0] DATA_IN = '0;
  logic          READY, READ_ENABLE_OUT;
  logic [DW-1:0] ADDRESS_OUT, X_OUT, R_OUT, H_OUT;
  logic          X_OUT_ENABLE, R_OUT_I_ENABLE, R_OUT_K_ENABLE, H_OUT_ENABLE;

  int checks = 0;
  int failures = 0;

  logic          c_rd   [0:63];
  logic [DW-1:0] c_addr [0:63];
  logic [4:0]    c_stb  [0:63];  // {x, r_i, r_k, h, ready}
  logic [DW-1:0] c_x    [0:63];
  logic [DW-1:0] c_r    [0:63];
  logic [DW-1:0] c_h    [0:63];
  logic [63:0]   start_mask;

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (READ_ENABLE_OUT) DATA_IN <= 64'd100 + ADDRESS_OUT;

  accelerator_trainer_feeder dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .SIZE_X_IN(SIZE_X_IN), .SIZE_W_IN(SIZE_W_IN), .SIZE_L_IN(SIZE_L_IN), .SIZE_R_IN(SIZE_R_IN),
    .ADDRESS_OUT(ADDRESS_OUT), .READ_ENABLE_OUT(READ_ENABLE_OUT), .DATA_IN(DATA_IN),
    .X_OUT_ENABLE(X_OUT_ENABLE), .X_OUT(X_OUT),
    .R_OUT_I_ENABLE(R_OUT_I_ENABLE), .R_OUT_K_ENABLE(R_OUT_K_ENABLE), .R_OUT(R_OUT),
    .H_OUT_ENABLE(H_OUT_ENABLE), .H_OUT(H_OUT)
  );

  // Edge 0 samples START; cycle c is sampled at the falling edge after edge c-1.
  task automatic capture(input int ncyc);
    @(posedge CLK);
    #1 START = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge CLK);
      c_rd[c]   = READ_ENABLE_OUT;
      c_addr[c] = ADDRESS_OUT;
      c_stb[c]  = {X_OUT_ENABLE, R_OUT_I_ENABLE, R_OUT_K_ENABLE, H_OUT_ENABLE, READY};
      c_x[c]    = X_OUT;
      c_r[c]    = R_OUT;
      c_h[c]    = H_OUT;
      START     = start_mask[c];
      if (c < ncyc) @(posedge CLK);
    end
  endtask

  task automatic launch(input logic [DW-1:0] sx, input logic [DW-1:0] sr,
                        input logic [DW-1:0] sw, input logic [DW-1:0] sl, input int ncyc);
    @(negedge CLK);
    SIZE_X_IN = sx;
    SIZE_R_IN = sr;
    SIZE_W_IN = sw;
    SIZE_L_IN = sl;
    START     = 1'b1;
    capture(ncyc);
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({READY, READ_ENABLE_OUT, X_OUT_ENABLE, R_OUT_I_ENABLE, R_OUT_K_ENABLE, H_OUT_ENABLE} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b expected=000000",
               {READY, READ_ENABLE_OUT, X_OUT_ENABLE, R_OUT_I_ENABLE, R_OUT_K_ENABLE, H_OUT_ENABLE});
    end
    checks++;
    if ({ADDRESS_OUT, X_OUT, R_OUT, H_OUT} !== {4 * DW{1'b0}}) begin
      failures++;
      $display("FAIL reset_buses got addr=%0h x=%0h r=%0h h=%0h expected all 0", ADDRESS_OUT, X_OUT, R_OUT, H_OUT);
    end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({READY, READ_ENABLE_OUT} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset got=%b expected=00", {READY, READ_ENABLE_OUT});
    end
  endtask

  task automatic test_mixed;
    logic [4:0] exp_stb;
    start_mask = '0;
    launch(2, 2, 2, 3, 14);
    for (int c = 1; c <= 14; c++) begin
      checks++;
      if (c_rd[c] !== (c <= 9)) begin
        failures++;
        $display("FAIL mixed_rd cycle %0d got=%b expected=%b", c, c_rd[c], (c <= 9));
      end
      if (c <= 9) begin
        checks++;
        if (c_addr[c] !== 64'(c - 1)) begin
          failures++;
          $display("FAIL mixed_addr cycle %0d got=%0d expected=%0d", c, c_addr[c], c - 1);
        end
      end
      exp_stb = {(c >= 3 && c <= 4), (c == 5 || c == 7), (c >= 5 && c <= 8), (c >= 9 && c <= 11), (c == 12)};
      checks++;
      if (c_stb[c] !== exp_stb) begin
        failures++;
        $display("FAIL mixed_strobes cycle %0d got=%b expected=%b", c, c_stb[c], exp_stb);
      end
      if (c >= 3 && c <= 4) begin
        checks++;
        if (c_x[c] !== 64'(100 + c - 3)) begin
          failures++;
          $display("FAIL mixed_x cycle %0d got=%0d expected=%0d", c, c_x[c], 100 + c - 3);
        end
      end
      if (c >= 5 && c <= 8) begin
        checks++;
        if (c_r[c] !== 64'(102 + c - 5)) begin
          failures++;
          $display("FAIL mixed_r cycle %0d got=%0d expected=%0d", c, c_r[c], 102 + c - 5);
        end
      end
      if (c >= 9 && c <= 11) begin
        checks++;
        if (c_h[c] !== 64'(106 + c - 9)) begin
          failures++;
          $display("FAIL mixed_h cycle %0d got=%0d expected=%0d", c, c_h[c], 106 + c - 9);
        end
      end
    end
    checks++;
    if ({c_x[13], c_r[13], c_h[13]} !== {64'd101, 64'd105, 64'd108}) begin
      failures++;
      $display("FAIL mixed_hold got x=%0d r=%0d h=%0d expected x=101 r=105 h=108", c_x[13], c_r[13], c_h[13]);
    end
  endtask

  task automatic test_empty_r;
    logic [4:0] exp_stb;
    start_mask = '0;
    launch(1, 0, 2, 1, 8);
    for (int c = 1; c <= 8; c++) begin
      exp_stb = {(c == 3), 1'b0, 1'b0, (c == 4), (c == 5)};
      checks++;
      if (c_stb[c] !== exp_stb || c_rd[c] !== (c <= 2)) begin
        failures++;
        $display("FAIL no_r_cycle cycle %0d got stb=%b rd=%b expected stb=%b rd=%b",
                 c, c_stb[c], c_rd[c], exp_stb, (c <= 2));
      end
    end
    checks++;
    if (c_x[3] !== 64'd100 || c_h[4] !== 64'd101 || c_addr[2] !== 64'd1) begin
      failures++;
      $display("FAIL no_r_data got x=%0d h=%0d addr2=%0d expected x=100 h=101 addr2=1", c_x[3], c_h[4], c_addr[2]);
    end
    launch(0, 2, 0, 1, 6);
    for (int c = 1; c <= 6; c++) begin
      exp_stb = {1'b0, 1'b0, 1'b0, (c == 3), (c == 4)};
      checks++;
      if (c_stb[c] !== exp_stb || c_rd[c] !== (c == 1)) begin
        failures++;
        $display("FAIL zero_w_cycle cycle %0d got stb=%b rd=%b expected stb=%b rd=%b",
                 c, c_stb[c], c_rd[c], exp_stb, (c == 1));
      end
    end
    checks++;
    if (c_h[3] !== 64'd100) begin
      failures++;
      $display("FAIL zero_w_data got h=%0d expected=100", c_h[3]);
    end
  endtask

  task automatic test_all_zero;
    start_mask = '0;
    launch(0, 0, 0, 0, 8);
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (c_stb[c] !== {4'b0, (c == 2)} || c_rd[c] !== 1'b0) begin
        failures++;
        $display("FAIL all_zero cycle %0d got stb=%b rd=%b expected stb=%b rd=0",
                 c, c_stb[c], c_rd[c], {4'b0, (c == 2)});
      end
    end
  endtask

  task automatic test_start_ignored;
    int n_rd, n_rdy;
    n_rd = 0;
    n_rdy = 0;
    start_mask = 64'h78;  // START high at edges 3..6
    launch(2, 2, 2, 3, 20);
    for (int c = 1; c <= 20; c++) begin
      if (c_rd[c] === 1'b1) n_rd++;
      if (c_stb[c][0] === 1'b1) n_rdy++;
    end
    checks++;
    if (n_rd != 9) begin
      failures++;
      $display("FAIL restart_reads got=%0d expected=9", n_rd);
    end
    checks++;
    if (n_rdy != 1 || c_stb[12][0] !== 1'b1) begin
      failures++;
      $display("FAIL restart_ready got count=%0d at12=%b expected count=1 at12=1", n_rdy, c_stb[12][0]);
    end
    checks++;
    if (c_addr[9] !== 64'd8 || c_h[11] !== 64'd108) begin
      failures++;
      $display("FAIL restart_tail got addr9=%0d h11=%0d expected addr9=8 h11=108", c_addr[9], c_h[11]);
    end
    start_mask = '0;
  endtask

  task automatic test_mid_reset;
    start_mask = '0;
    launch(2, 2, 2, 3, 4);
    checks++;
    if (c_x[4] !== 64'd101 || c_rd[4] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got x=%0d rd=%b expected x=101 rd=1", c_x[4], c_rd[4]);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({READY, READ_ENABLE_OUT, X_OUT_ENABLE, R_OUT_I_ENABLE, R_OUT_K_ENABLE, H_OUT_ENABLE} !== 6'b0 ||
        {ADDRESS_OUT, X_OUT, R_OUT, H_OUT} !== {4 * DW{1'b0}}) begin
      failures++;
      $display("FAIL mid_reset got rd=%b addr=%0h x=%0h r=%0h h=%0h expected all 0",
               READ_ENABLE_OUT, ADDRESS_OUT, X_OUT, R_OUT, H_OUT);
    end
    RST = 1'b1;
    launch(1, 0, 0, 0, 6);
    checks++;
    if (c_rd[1] !== 1'b1 || c_addr[1] !== 64'd0) begin
      failures++;
      $display("FAIL post_reset_addr got rd=%b addr=%0d expected rd=1 addr=0", c_rd[1], c_addr[1]);
    end
    checks++;
    if (c_stb[3] !== 5'b10000 || c_x[3] !== 64'd100 || c_stb[4] !== 5'b00001) begin
      failures++;
      $display("FAIL post_reset_out got stb3=%b x=%0d stb4=%b expected stb3=10000 x=100 stb4=00001",
               c_stb[3], c_x[3], c_stb[4]);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_rd;
    start_mask = '0;
    start_mask[6] = 1'b1;
    launch(1, 1, 1, 1, 14);
    for (int c = 1; c <= 14; c++) begin
      exp_rd = (c <= 3) || (c >= 7 && c <= 9);
      checks++;
      if (c_rd[c] !== exp_rd || c_stb[c][0] !== (c == 6 || c == 12)) begin
        failures++;
        $display("FAIL b2b_cycle cycle %0d got rd=%b ready=%b expected rd=%b ready=%b",
                 c, c_rd[c], c_stb[c][0], exp_rd, (c == 6 || c == 12));
      end
    end
    checks++;
    if (c_addr[7] !== 64'd0 || c_addr[9] !== 64'd2) begin
      failures++;
      $display("FAIL b2b_addr got a7=%0d a9=%0d expected a7=0 a9=2", c_addr[7], c_addr[9]);
    end
    checks++;
    if (c_stb[9] !== 5'b10000 || c_x[9] !== 64'd100 || c_stb[10] !== 5'b01100 || c_r[10] !== 64'd101 ||
        c_stb[11] !== 5'b00010 || c_h[11] !== 64'd102) begin
      failures++;
      $display("FAIL b2b_out got s9=%b x=%0d s10=%b r=%0d s11=%b h=%0d expected s9=10000 x=100 s10=01100 r=101 s11=00010 h=102",
               c_stb[9], c_x[9], c_stb[10], c_r[10], c_stb[11], c_h[11]);
    end
    start_mask = '0;
  endtask

  initial begin
    start_mask = '0;
    test_reset();
    test_mixed();
    test_empty_r();
    test_all_zero();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accelerator_trainer_feeder.md
# accelerator_trainer_feeder

Streams the training operands x(t), r(t;i;k) and h(t;l) from a synchronous-read operand buffer into the FNN trainer's X/R/H input ports with that port set's loop-boundary enable strobes. It is the transmitting end of the trainer's input interface. On START it walks one contiguous buffer region and emits every element on the matching output bus with the matching strobe, then pulses READY. It sits between the per-timestep operand buffer and accelerator_trainer.

## Interface
- DATA_SIZE, 64, width of data, address and size words
- CONTROL_SIZE, 64, width of internal loop counters
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset; one clock; reset is asynchronous and active-low
- START  in  1  begin one transfer; sampled only in STARTER
- READY  out  1  one-cycle pulse when the last element has been emitted
- SIZE_X_IN, SIZE_W_IN, SIZE_L_IN, SIZE_R_IN  in  DATA_SIZE  each  vector/matrix dimensions; latched on accepted START
- ADDRESS_OUT  out  DATA_SIZE  buffer read address
- READ_ENABLE_OUT  out  1  buffer read request
- DATA_IN  in  DATA_SIZE  buffer read data, valid exactly one cycle after the request
- X_OUT_ENABLE  out  1  strobe, one per x element
- X_OUT  out  DATA_SIZE  x element
- R_OUT_I_ENABLE  out  1  strobe on the first element (k=0) of each read head i
- R_OUT_K_ENABLE  out  1  strobe, one per r element
- R_OUT  out  DATA_SIZE  r element
- H_OUT_ENABLE  out  1  strobe, one per h element
- H_OUT  out  DATA_SIZE  h element

## Operation
- FSM states: STARTER, READ_X, READ_R, READ_H, DRAIN, DONE.
- STARTER:
  - Accepting START latches the sizes and clears the address counter and the i, k and element counters.
  - Next state is the first phase with nonzero size, in the order X (SIZE_X), R (SIZE_R × SIZE_W, i outer, k inner), H (SIZE_L).
  - If every phase is empty, next state is DONE.
  - R is empty if SIZE_R = 0 or SIZE_W = 0.
- READ_* phases:
  - One read per cycle: READ_ENABLE_OUT = 1 and ADDRESS_OUT = current address counter.
  - The address counter increments after every read and is never reset between phases, so the three regions are contiguous starting at 0.
  - A phase advances to the next nonempty phase after its last read, or to DRAIN if no phase remains.
- DRAIN: no reads; waits until the last element has been emitted, then goes to DONE.
- DONE: READY = 1 for exactly one cycle, then STARTER.
- Each read carries a tag {phase, first-of-row} through a 2-stage aligner, so the strobe and data word leave together.
- R_OUT_I_ENABLE and R_OUT_K_ENABLE are both high on a k = 0 element.
- Output data registers change only when their own strobe is asserted; otherwise they hold their last value.
- START outside STARTER is ignored. Size inputs are ignored after latching.
- Address counter wraps modulo 2^DATA_SIZE without error.
- Asserting RST mid-transfer aborts it: all outputs return to reset values, state goes to STARTER, and the pipeline is flushed.

## Timing
- Reset values: READY, READ_ENABLE_OUT and all strobes 0; ADDRESS_OUT, X_OUT, R_OUT, H_OUT 0.
- START sampled at edge 0 → first read visible in cycle 1.
- Read issued in cycle k → DATA_IN in cycle k+1 → output bus and strobe registered and visible in cycle k+2.
- N = SIZE_X + SIZE_R·SIZE_W + SIZE_L reads occupy cycles 1..N with no gaps, including across phase changes.
- Outputs appear in cycles 3..N+2; READY pulses in cycle N+3.
- All sizes zero: READY pulses in cycle 2, and no reads or strobes occur.
- At most one strobe group is active per cycle.
- A new START is accepted in the cycle READY is high, i.e. the FSM is back in STARTER by then.

## Structure
- Shared package accelerator_trainer_pkg holds the FSM state encodings and the ZERO/ONE_DATA and ZERO/ONE_CONTROL constants, used by both trainer and feeder.
- Sub-module accelerator_read_aligner:
  - 2-stage valid + tag pipeline matching the buffer latency, parameterized on tag width.
  - The feeder instantiates it once.

## Test plan
- SIZE_X=2, SIZE_R=2, SIZE_W=2, SIZE_L=3, buffer[a]=100+a, START at edge 0:
  - reads of addresses 0..8 in cycles 1..9;
  - X_OUT 100, 101 in cycles 3–4;
  - R_OUT 102..105 in cycles 5–8, with R_OUT_I_ENABLE in cycles 5 and 7;
  - H_OUT 106..108 in cycles 9–11;
  - READY in cycle 12.
- SIZE_R=0, SIZE_X=1, SIZE_L=1 → no R strobes; X_OUT=100 in cycle 3, H_OUT=101 in cycle 4, READY in cycle 5.
- All sizes 0 → no READ_ENABLE_OUT; READY in cycle 2 only.
- START re-pulsed in cycles 3–6 of a 9-read transfer → ignored; exactly 9 reads and one READY.
- RST low in cycle 5 of a transfer → all outputs 0 the same cycle; after release, a fresh START restarts at address 0.
- Back-to-back: START asserted in the cycle READY is high → second transfer begins reading one cycle later, at address 0.
